// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// Values are loaded by valid/ready and swapped in only at frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter bit          ACTIVE_LOW_OUT = 1'b1
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [4*DIGITS-1:0]       value_in,
  input  logic [DIGITS-1:0]         dp_in,
  input  logic                      lz_suppress,
  input  logic                      load_valid,
  output logic                      load_ready,
  output logic [DIGITS-1:0]         an_out,
  output logic [6:0]                seg_out,
  output logic                      dp_out,
  output logic [$clog2(DIGITS)-1:0] scan_idx,
  output logic                      frame_done
);

  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam int unsigned PreW = $clog2(REFRESH_DIV);
  localparam logic [PreW-1:0] PreLast   = PreW'(REFRESH_DIV - 1);
  localparam logic [PreW-1:0] BlankLast = PreW'(BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e                state_q, state_d;
  logic [PreW-1:0]       presc_q, presc_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0]   act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  logic                  xfer;
  logic                  last_cycle;
  logic [4*DIGITS-1:0]   val_shift;
  logic [3:0]            cur_nib;
  logic [DIGITS-1:0]     sup;
  logic                  hi_zero;
  logic [DIGITS-1:0]     an_h;
  logic [6:0]            seg_h;
  logic                  dp_h;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;
      4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;
      4'hF: hex7 = 7'b1110001;
    endcase
  endfunction

  assign xfer       = load_valid && !pend_valid_q;
  assign last_cycle = (state_q == StDrive) && (presc_q == PreLast) && (idx_q == IdxLast);
  assign load_ready = !pend_valid_q;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = StIdle;
      presc_d = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          presc_d = '0;
          idx_d   = '0;
        end
        StBlank: begin
          presc_d = presc_q + 1'b1;
          if (presc_q == BlankLast) state_d = StDrive;
        end
        StDrive: begin
          if (presc_q == PreLast) begin
            state_d = StBlank;
            presc_d = '0;
            idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Idle loads go straight to active; while scanning, loads wait for the frame boundary.
  always_comb begin
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    if (state_q == StIdle) begin
      if (xfer) begin
        act_val_d = value_in;
        act_dp_d  = dp_in;
      end
    end else if (last_cycle) begin
      if (pend_valid_q) begin
        act_val_d    = pend_val_q;
        act_dp_d     = pend_dp_q;
        pend_valid_d = 1'b0;
      end else if (xfer) begin
        act_val_d = value_in;
        act_dp_d  = dp_in;
      end
    end else if (xfer) begin
      pend_val_d   = value_in;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    val_shift = act_val_q >> {idx_q, 2'b00};
    cur_nib   = val_shift[3:0];
    sup       = '0;
    hi_zero   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hi_zero = hi_zero && (act_val_q[4*k +: 4] == 4'h0);
      sup[k]  = lz_suppress && hi_zero && !act_dp_q[k];
    end
    an_h  = '0;
    seg_h = '0;
    dp_h  = 1'b0;
    if (enable && (state_q == StDrive) && !sup[idx_q]) begin
      an_h  = DIGITS'(1) << idx_q;
      seg_h = hex7(cur_nib);
      dp_h  = act_dp_q[idx_q];
    end
    an_d  = an_h ^ {DIGITS{ACTIVE_LOW_OUT}};
    seg_d = seg_h ^ {7{ACTIVE_LOW_OUT}};
    dp_d  = dp_h ^ ACTIVE_LOW_OUT;
    fd_d  = (state_d == StDrive) && (presc_d == PreLast) && (idx_d == IdxLast);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      idx_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      an_q         <= {DIGITS{ACTIVE_LOW_OUT}};
      seg_q        <= {7{ACTIVE_LOW_OUT}};
      dp_q         <= ACTIVE_LOW_OUT;
      fd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      fd_q         <= fd_d;
    end
  end

  assign an_out     = an_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign scan_idx   = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl; expectations are queued with a target cycle
// and compared by a negedge monitor when that cycle arrives.
module tb_seg_scan_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_suppress = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [1:0]  scan_idx;
  logic        frame_done;

  seg_scan_ctrl #(
    .DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW_OUT(1'b1)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .value_in(value_in), .dp_in(dp_in),
    .lz_suppress(lz_suppress), .load_valid(load_valid), .load_ready(load_ready),
    .an_out(an_out), .seg_out(seg_out), .dp_out(dp_out), .scan_idx(scan_idx),
    .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int         id;
    int         cyc;
    int         kind;
    logic [7:0] val;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  string kname[6] = '{"an", "seg", "dp", "frame_done", "load_ready", "scan_idx"};

  function automatic logic [6:0] hex_hi(input logic [3:0] n);
    case (n)
      4'h0: hex_hi = 7'b0111111;  4'h1: hex_hi = 7'b0000110;
      4'h2: hex_hi = 7'b1011011;  4'h3: hex_hi = 7'b1001111;
      4'h4: hex_hi = 7'b1100110;  4'h5: hex_hi = 7'b1101101;
      4'h6: hex_hi = 7'b1111101;  4'h7: hex_hi = 7'b0000111;
      4'h8: hex_hi = 7'b1111111;  4'h9: hex_hi = 7'b1101111;
      4'hA: hex_hi = 7'b1110111;  4'hB: hex_hi = 7'b1111100;
      4'hC: hex_hi = 7'b0111001;  4'hD: hex_hi = 7'b1011110;
      4'hE: hex_hi = 7'b1111001;  4'hF: hex_hi = 7'b1110001;
    endcase
  endfunction

  function automatic logic [7:0] observe(input int kind);
    case (kind)
      0:       observe = {4'b0, an_out};
      1:       observe = {1'b0, seg_out};
      2:       observe = {7'b0, dp_out};
      3:       observe = {7'b0, frame_done};
      4:       observe = {7'b0, load_ready};
      default: observe = {6'b0, scan_idx};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("%s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int id, input int c, input int kind, input logic [7:0] v);
    exp_t e;
    int   i;
    e = '{id: id, cyc: c, kind: kind, val: v};
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  // Expected digit in the middle of its driven window, relative to frame base.
  task automatic exp_slot(input int id, input int base, input int slot, input logic [3:0] an,
                          input logic [3:0] nib);
    int c;
    c = base + 6 + 8 * slot;
    push(id, c, 0, {4'b0, an});
    push(id, c, 1, {1'b0, ~hex_hi(nib)});
    push(id, c, 5, 8'(slot));
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  always @(negedge clk_in) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) begin
        checks++;
        assert (mon_e.cyc == cyc) else begin
          errors++;
          $display("FAIL missed_s%0d_%s observed=%0d expected=%0d", mon_e.id,
                   kname[mon_e.kind], cyc, mon_e.cyc);
          $error("missed expectation");
        end
      end else begin
        chk($sformatf("s%0d_%s@%0d", mon_e.id, kname[mon_e.kind], mon_e.cyc),
            observe(mon_e.kind), mon_e.val);
      end
    end
  end

  initial begin
    int c0, b, b2, b3, b4, b5, b6, c1, c2;

    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_an", {4'b0, an_out}, 8'h0F);
    chk("rst_seg", {1'b0, seg_out}, 8'h7F);
    chk("rst_dp", {7'b0, dp_out}, 8'h01);
    chk("rst_ready", {7'b0, load_ready}, 8'h01);
    chk("rst_fd", {7'b0, frame_done}, 8'h00);
    chk("rst_idx", {6'b0, scan_idx}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk_in);

    // 1: load while idle, then scan
    value_in = 16'h12A0; dp_in = 4'b0000; load_valid = 1'b1;
    @(negedge clk_in);
    load_valid = 1'b0;
    chk("s1_idle_ready", {7'b0, load_ready}, 8'h01);
    @(negedge clk_in);
    c0 = cyc;
    enable = 1'b1;
    push(1, c0, 0, 8'h0F);
    push(1, c0, 3, 8'h00);
    push(1, c0 + 3, 0, 8'h0F);
    push(1, c0 + 4, 0, 8'h0E);
    push(1, c0 + 4, 1, 8'h40);
    push(1, c0 + 9, 0, 8'h0E);
    push(1, c0 + 9, 1, 8'h40);
    push(1, c0 + 10, 0, 8'h0F);
    exp_slot(1, c0, 1, 4'b1101, 4'hA);
    exp_slot(1, c0, 2, 4'b1011, 4'h2);
    exp_slot(1, c0, 3, 4'b0111, 4'h1);
    push(1, c0 + 31, 3, 8'h00);
    push(1, c0 + 32, 3, 8'h01);
    push(1, c0 + 33, 3, 8'h00);
    push(1, c0 + 64, 3, 8'h01);
    wait_cyc(c0 + 65);

    // 2: leading-zero suppression
    value_in = 16'h0050; lz_suppress = 1'b1; load_valid = 1'b1;
    b = c0 + 96;
    push(2, c0 + 66, 4, 8'h00);
    push(2, b + 1, 4, 8'h01);
    exp_slot(2, b, 0, 4'b1110, 4'h0);
    exp_slot(2, b, 1, 4'b1101, 4'h5);
    for (int k = b + 18; k <= b + 33; k++) push(2, k, 0, 8'h0F);
    @(negedge clk_in);
    load_valid = 1'b0;
    wait_cyc(b + 33);
    lz_suppress = 1'b0;
    exp_slot(2, b + 32, 2, 4'b1011, 4'h0);
    exp_slot(2, b + 32, 3, 4'b0111, 4'h0);

    // 3: tear-free update with a stalled second load
    b2 = b + 64;
    b3 = b2 + 32;
    b4 = b3 + 32;
    push(3, b2 + 13, 4, 8'h00);
    push(3, b2 + 20, 4, 8'h00);
    push(3, b2 + 32, 4, 8'h00);
    push(3, b2 + 32, 3, 8'h01);
    push(3, b2 + 33, 4, 8'h01);
    push(3, b2 + 34, 4, 8'h00);
    exp_slot(3, b2, 3, 4'b0111, 4'h0);
    exp_slot(3, b3, 0, 4'b1110, 4'h1);
    exp_slot(3, b3, 3, 4'b0111, 4'h1);
    exp_slot(3, b4, 0, 4'b1110, 4'h2);
    exp_slot(3, b4, 3, 4'b0111, 4'h2);
    push(3, b4 + 1, 4, 8'h01);
    wait_cyc(b2 + 12);
    value_in = 16'h1111; load_valid = 1'b1;
    @(negedge clk_in);
    value_in = 16'h2222;
    wait_cyc(b2 + 34);
    load_valid = 1'b0;

    // 4: load in the frame_done cycle bypasses to active
    b5 = b4 + 32;
    push(4, b5, 3, 8'h01);
    push(4, b5, 4, 8'h01);
    push(4, b5 + 1, 4, 8'h01);
    exp_slot(4, b5, 0, 4'b1110, 4'h7);
    push(4, b5 + 6, 2, 8'h00);
    exp_slot(4, b5, 1, 4'b1101, 4'h0);
    push(4, b5 + 14, 2, 8'h01);
    wait_cyc(b5);
    value_in = 16'h0007; dp_in = 4'b0001; load_valid = 1'b1;
    @(negedge clk_in);
    load_valid = 1'b0; dp_in = 4'b0000;

    // 5: enable drop mid-drive and restart
    b6 = b5 + 32;
    push(5, b6 + 21, 0, 8'h0B);
    push(5, b6 + 22, 0, 8'h0F);
    push(5, b6 + 22, 1, 8'h7F);
    push(5, b6 + 22, 5, 8'h00);
    push(5, b6 + 32, 3, 8'h00);
    wait_cyc(b6 + 21);
    enable = 1'b0;
    wait_cyc(b6 + 25);
    enable = 1'b1;
    c1 = cyc;
    push(5, c1 + 2, 0, 8'h0F);
    push(5, c1 + 3, 0, 8'h0F);
    push(5, c1 + 4, 0, 8'h0E);
    push(5, c1 + 4, 1, {1'b0, ~hex_hi(4'h7)});

    // 6: async reset with a pending value
    push(6, c1 + 11, 4, 8'h00);
    push(6, c1 + 14, 4, 8'h00);
    push(6, c1 + 14, 0, 8'h0D);
    wait_cyc(c1 + 10);
    value_in = 16'h3333; load_valid = 1'b1;
    @(negedge clk_in);
    load_valid = 1'b0;
    wait_cyc(c1 + 14);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_async_an", {4'b0, an_out}, 8'h0F);
    chk("s6_async_seg", {1'b0, seg_out}, 8'h7F);
    chk("s6_async_dp", {7'b0, dp_out}, 8'h01);
    chk("s6_async_ready", {7'b0, load_ready}, 8'h01);
    enable = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("s6_idle_an", {4'b0, an_out}, 8'h0F);
    chk("s6_idle_idx", {6'b0, scan_idx}, 8'h00);
    chk("s6_idle_fd", {7'b0, frame_done}, 8'h00);
    enable = 1'b1;
    c2 = cyc;
    push(6, c2 + 1, 4, 8'h01);
    exp_slot(6, c2, 0, 4'b1110, 4'h0);
    exp_slot(6, c2, 1, 4'b1101, 4'h0);
    exp_slot(6, c2, 3, 4'b0111, 4'h0);
    wait_cyc(c2 + 40);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $display("FAIL sb_drain observed=%0d expected=0", sb.size());
      $error("scoreboard not drained");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
